// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a fixed-latency ALU.
// One operation in flight; the result is held until the consumer accepts it.
module alu_arbiter #(
  parameter int unsigned DW      = 8,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [DW-1:0] req0_A,
  input  logic [DW-1:0] req1_A,
  input  logic [DW-1:0] req0_B,
  input  logic [DW-1:0] req1_B,
  input  logic          req0_a_en,
  input  logic          req0_b_en,
  input  logic          req1_a_en,
  input  logic          req1_b_en,
  input  logic [2:0]    req0_a_op,
  input  logic [2:0]    req1_a_op,
  input  logic [1:0]    req0_b_op,
  input  logic [1:0]    req1_b_op,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic          ALU_en,
  output logic          a_en,
  output logic          b_en,
  output logic [2:0]    a_op,
  output logic [1:0]    b_op,
  input  logic [DW-1:0] C,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_data,
  output logic          resp_id,
  output logic          busy,
  output logic [15:0]   op_cnt
);

  localparam int unsigned LCW = 3;
  localparam int unsigned CNTW = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  a_q, b_q;
  logic           aen_q, ben_q, id_q;
  logic [2:0]     aop_q;
  logic [1:0]     bop_q;
  logic           last_grant_q;
  logic [LCW-1:0] lat_cnt_q;
  logic [CNTW-1:0] op_cnt_q;
  logic           grant;
  logic           accept, capture, resp_hs;

  // On a tie the requester that did not win last time gets the slot.
  assign grant = (&req_valid) ? ~last_grant_q : req_valid[1];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    A         = '0;
    B         = '0;
    ALU_en    = 1'b0;
    a_en      = 1'b0;
    b_en      = 1'b0;
    a_op      = 3'd0;
    b_op      = 2'd0;
    accept    = 1'b0;
    capture   = 1'b0;
    resp_hs   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready[grant] = 1'b1;
          accept           = 1'b1;
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        ALU_en  = 1'b1;
        A       = a_q;
        B       = b_q;
        a_en    = aen_q;
        b_en    = ben_q;
        a_op    = aop_q;
        b_op    = bop_q;
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_cnt_q <= LCW'(1)) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_hs = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, latency counter, result capture and completion bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      aen_q        <= 1'b0;
      ben_q        <= 1'b0;
      aop_q        <= 3'd0;
      bop_q        <= 2'd0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      lat_cnt_q    <= '0;
      resp_data    <= '0;
      resp_id      <= 1'b0;
      op_cnt_q     <= '0;
    end else begin
      if (accept) begin
        a_q   <= grant ? req1_A    : req0_A;
        b_q   <= grant ? req1_B    : req0_B;
        aen_q <= grant ? req1_a_en : req0_a_en;
        ben_q <= grant ? req1_b_en : req0_b_en;
        aop_q <= grant ? req1_a_op : req0_a_op;
        bop_q <= grant ? req1_b_op : req0_b_op;
        id_q  <= grant;
      end
      if (state_q == ISSUE)     lat_cnt_q <= LCW'(ALU_LAT);
      else if (state_q == WAIT) lat_cnt_q <= lat_cnt_q - LCW'(1);
      if (capture) begin
        resp_data <= C;
        resp_id   <= id_q;
      end
      if (resp_hs) begin
        last_grant_q <= resp_id;
        op_cnt_q     <= op_cnt_q + CNTW'(1);
      end
    end
  end

  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign op_cnt     = op_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one DUT at ALU_LAT=1, one at ALU_LAT=3,
// each fed by an adder stub that registers A+B on ALU_en.
module tb_alu_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, resp_ready;
  logic [1:0] req_valid;
  logic [7:0] req0_A, req1_A, req0_B, req1_B;
  logic       req0_a_en, req0_b_en, req1_a_en, req1_b_en;
  logic [2:0] req0_a_op, req1_a_op;
  logic [1:0] req0_b_op, req1_b_op;

  logic [1:0] req_ready, req_ready3;
  logic [7:0] a, b, c, a3, b3, c3;
  logic       alu_en, a_en, b_en, alu_en3, a_en3, b_en3;
  logic [2:0] a_op, a_op3;
  logic [1:0] b_op, b_op3;
  logic       resp_valid, resp_id, busy, resp_valid3, resp_id3, busy3;
  logic [7:0] resp_data, resp_data3;
  logic [15:0] op_cnt, op_cnt3;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  always_ff @(posedge clk) if (alu_en)  c  <= a + b;
  always_ff @(posedge clk) if (alu_en3) c3 <= a3 + b3;

  alu_arbiter #(.DW(8), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_A(req0_A), .req1_A(req1_A), .req0_B(req0_B), .req1_B(req1_B),
    .req0_a_en(req0_a_en), .req0_b_en(req0_b_en), .req1_a_en(req1_a_en), .req1_b_en(req1_b_en),
    .req0_a_op(req0_a_op), .req1_a_op(req1_a_op), .req0_b_op(req0_b_op), .req1_b_op(req1_b_op),
    .A(a), .B(b), .ALU_en(alu_en), .a_en(a_en), .b_en(b_en), .a_op(a_op), .b_op(b_op),
    .C(c), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id), .busy(busy), .op_cnt(op_cnt));

  alu_arbiter #(.DW(8), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready3),
    .req0_A(req0_A), .req1_A(req1_A), .req0_B(req0_B), .req1_B(req1_B),
    .req0_a_en(req0_a_en), .req0_b_en(req0_b_en), .req1_a_en(req1_a_en), .req1_b_en(req1_b_en),
    .req0_a_op(req0_a_op), .req1_a_op(req1_a_op), .req0_b_op(req0_b_op), .req1_b_op(req1_b_op),
    .A(a3), .B(b3), .ALU_en(alu_en3), .a_en(a_en3), .b_en(b_en3), .a_op(a_op3), .b_op(b_op3),
    .C(c3), .resp_valid(resp_valid3), .resp_ready(resp_ready), .resp_data(resp_data3),
    .resp_id(resp_id3), .busy(busy3), .op_cnt(op_cnt3));

  task automatic go_posedge; @(posedge clk); #1; endtask
  task automatic go_negedge; @(negedge clk); endtask

  task automatic do_reset;
    go_posedge;
    rst = 1'b1; req_valid = 2'b00; resp_ready = 1'b1;
    go_posedge;
    go_posedge;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    go_posedge;
    go_posedge;
    go_negedge;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    checks++; if ({alu_en, a_en, b_en, a, b, a_op, b_op} !== 23'd0) begin failures++; $display("FAIL rst_alu_outputs en=%b a=%0d b=%0d exp=0", alu_en, a, b); end
    go_posedge;
    rst = 1'b0;
    go_negedge;
    checks++; if (op_cnt !== 16'd0) begin failures++; $display("FAIL rst_op_cnt got=%0d exp=0", op_cnt); end
    checks++; if ({resp_data, resp_id} !== 9'd0) begin failures++; $display("FAIL rst_resp got data=%0d id=%b exp=0/0", resp_data, resp_id); end
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL rst_req_ready got=%b exp=00", req_ready); end
  endtask

  task automatic test_single;
    do_reset;
    req_valid = 2'b01; req0_A = 8'd3; req0_B = 8'd4;
    req0_a_en = 1'b1; req0_b_en = 1'b1; req0_a_op = 3'd5; req0_b_op = 2'd2;
    go_negedge;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL single_ready got=%b exp=01", req_ready); end
    checks++; if (alu_en !== 1'b0) begin failures++; $display("FAIL single_idle_alu_en got=%b exp=0", alu_en); end
    go_negedge;
    checks++; if ({alu_en, a, b} !== {1'b1, 8'd3, 8'd4}) begin failures++; $display("FAIL single_issue got en=%b a=%0d b=%0d exp 1/3/4", alu_en, a, b); end
    checks++; if ({a_en, b_en, a_op, b_op} !== {1'b1, 1'b1, 3'd5, 2'd2}) begin failures++; $display("FAIL single_fields got %b%b op=%0d/%0d exp 11 5/2", a_en, b_en, a_op, b_op); end
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL single_issue_ready got=%b exp=00", req_ready); end
    go_negedge;
    checks++; if ({alu_en, a_en, b_en, a, b, a_op, b_op} !== 23'd0) begin failures++; $display("FAIL single_wait_alu got en=%b a=%0d op=%0d exp=0", alu_en, a, a_op); end
    checks++; if ({busy, resp_valid} !== 2'b10) begin failures++; $display("FAIL single_wait_state got busy=%b rv=%b exp 1/0", busy, resp_valid); end
    go_negedge;
    checks++; if ({resp_valid, resp_data, resp_id} !== {1'b1, 8'd7, 1'b0}) begin failures++; $display("FAIL single_resp got rv=%b data=%0d id=%b exp 1/7/0", resp_valid, resp_data, resp_id); end
    go_posedge;
    req_valid = 2'b00;
    go_negedge;
    checks++; if ({op_cnt, busy, resp_valid} !== {16'd1, 1'b0, 1'b0}) begin failures++; $display("FAIL single_done got cnt=%0d busy=%b rv=%b exp 1/0/0", op_cnt, busy, resp_valid); end
  endtask

  task automatic test_round_robin;
    int last_acc;
    bit found;
    logic exp_g;
    do_reset;
    req0_A = 8'd1; req0_B = 8'd1; req1_A = 8'd10; req1_B = 8'd10;
    req_valid = 2'b11;
    last_acc = 0;
    for (int k = 0; k < 4; k++) begin
      exp_g = k[0];
      found = 1'b0;
      for (int t = 0; t < 20 && !found; t++) begin go_negedge; found = (req_ready != 2'b00); end
      checks++; if (!found || req_ready !== (exp_g ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", k, req_ready, exp_g ? 2'b10 : 2'b01); end
      if (k > 0) begin
        checks++; if (cyc_n - last_acc !== 4) begin failures++; $display("FAIL rr_interval%0d got=%0d exp=4", k, cyc_n - last_acc); end
      end
      last_acc = cyc_n;
      found = 1'b0;
      for (int t = 0; t < 20 && !found; t++) begin go_negedge; found = resp_valid; end
      checks++; if (!found || {resp_id, resp_data} !== {exp_g, exp_g ? 8'd20 : 8'd2}) begin failures++; $display("FAIL rr_resp%0d got id=%b data=%0d exp %b/%0d", k, resp_id, resp_data, exp_g, exp_g ? 20 : 2); end
    end
    go_posedge;
    req_valid = 2'b00;
    go_negedge;
    checks++; if (op_cnt !== 16'd4) begin failures++; $display("FAIL rr_op_cnt got=%0d exp=4", op_cnt); end
  endtask

  task automatic test_backpressure;
    bit found;
    do_reset;
    resp_ready = 1'b0; req1_A = 8'd5; req1_B = 8'd6; req_valid = 2'b10;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin go_negedge; found = resp_valid; end
    checks++; if (!found) begin failures++; $display("FAIL bp_resp_timeout got rv=%b exp=1", resp_valid); end
    go_posedge;
    req_valid = 2'b11;
    for (int t = 0; t < 10; t++) begin
      go_negedge;
      checks++;
      if ({resp_valid, resp_data, resp_id, req_ready, alu_en} !== {1'b1, 8'd11, 1'b1, 2'b00, 1'b0}) begin
        failures++;
        $display("FAIL bp_hold%0d got rv=%b data=%0d id=%b rdy=%b en=%b exp 1/11/1/00/0", t, resp_valid, resp_data, resp_id, req_ready, alu_en);
      end
    end
    go_posedge;
    resp_ready = 1'b1;
    go_negedge;
    go_negedge;
    checks++; if ({resp_valid, op_cnt} !== {1'b0, 16'd1}) begin failures++; $display("FAIL bp_complete got rv=%b cnt=%0d exp 0/1", resp_valid, op_cnt); end
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL bp_next_grant got=%b exp=01", req_ready); end
    go_posedge;
    req_valid = 2'b00;
  endtask

  task automatic test_reset_mid;
    bit found, quiet;
    do_reset;
    req0_A = 8'd3; req0_B = 8'd4; req_valid = 2'b01;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin go_negedge; found = resp_valid; end
    go_negedge;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin go_negedge; found = alu_en; end
    checks++; if (!found) begin failures++; $display("FAIL mid_second_issue got en=%b exp=1", alu_en); end
    go_negedge;
    checks++; if ({busy, resp_valid, op_cnt} !== {1'b1, 1'b0, 16'd1}) begin failures++; $display("FAIL mid_wait got busy=%b rv=%b cnt=%0d exp 1/0/1", busy, resp_valid, op_cnt); end
    rst = 1'b1; req_valid = 2'b00;
    go_negedge;
    checks++; if ({busy, resp_valid, alu_en, op_cnt} !== 19'd0) begin failures++; $display("FAIL mid_after_rst got busy=%b rv=%b en=%b cnt=%0d exp=0", busy, resp_valid, alu_en, op_cnt); end
    go_posedge;
    rst = 1'b0;
    quiet = 1'b1;
    for (int t = 0; t < 4; t++) begin go_negedge; if (resp_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0; end
    checks++; if (!quiet) begin failures++; $display("FAIL mid_no_resp got rv=%b busy=%b exp 0/0", resp_valid, busy); end
    go_posedge;
    req_valid = 2'b11;
    go_negedge;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL mid_grant got=%b exp=01", req_ready); end
    go_posedge;
    req_valid = 2'b00;
  endtask

  task automatic test_lat3;
    int t0;
    bit found;
    do_reset;
    req0_A = 8'd200; req0_B = 8'd100; req_valid = 2'b01;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin go_negedge; found = (req_ready3 != 2'b00); end
    checks++; if (!found || req_ready3 !== 2'b01) begin failures++; $display("FAIL lat3_accept got=%b exp=01", req_ready3); end
    t0 = cyc_n;
    go_posedge;
    req_valid = 2'b00;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin go_negedge; found = resp_valid3; end
    checks++; if (!found || cyc_n - t0 !== 5) begin failures++; $display("FAIL lat3_latency got=%0d exp=5", cyc_n - t0); end
    checks++; if ({resp_data3, resp_id3} !== {8'd44, 1'b0}) begin failures++; $display("FAIL lat3_data got=%0d id=%b exp 44/0", resp_data3, resp_id3); end
  endtask

  task automatic test_wrap;
    bit found;
    do_reset;
    go_negedge;
    force dut.op_cnt_q = 16'hFFFF;
    go_posedge;
    go_negedge;
    release dut.op_cnt_q;
    go_posedge;
    go_negedge;
    checks++; if (op_cnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload got=%0d exp=65535", op_cnt); end
    go_posedge;
    req0_A = 8'd1; req0_B = 8'd1; req_valid = 2'b01;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin go_negedge; found = resp_valid; end
    go_posedge;
    req_valid = 2'b00;
    go_negedge;
    checks++; if (!found || op_cnt !== 16'd0) begin failures++; $display("FAIL wrap_op_cnt got=%0d exp=0", op_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; resp_ready = 1'b1; req_valid = 2'b00;
    req0_A = '0; req1_A = '0; req0_B = '0; req1_B = '0;
    req0_a_en = 1'b0; req0_b_en = 1'b0; req1_a_en = 1'b0; req1_b_en = 1'b0;
    req0_a_op = '0; req1_a_op = '0; req0_b_op = '0; req1_b_op = '0;
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_reset_mid;
    test_lat3;
    test_wrap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
